// File: rtl/bbox_overlay_if.sv
// Pixel stream bundle for bbox_overlay: the incoming camera stream and the
// one-cycle-delayed, overlaid outgoing stream.
interface bbox_overlay_if;
  logic        in_vsync;
  logic        in_href;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_vsync;
  logic        out_href;
  logic        out_valid;
  logic [15:0] out_data;

  modport master (
    output in_vsync, in_href, in_valid, in_data,
    input  out_vsync, out_href, out_valid, out_data
  );

  modport slave (
    input  in_vsync, in_href, in_valid, in_data,
    output out_vsync, out_href, out_valid, out_data
  );
endinterface

// File: rtl/bbox_overlay.sv
// Draws a LINE_W-thick rectangular border in BOX_COLOR over an RGB565 pixel stream.
// Every output is its input delayed by exactly one clock; the box is re-latched per frame.
module bbox_overlay #(
  parameter logic [9:0]  IMG_HDISP = 10'd640,
  parameter logic [9:0]  IMG_VDISP = 10'd480,
  parameter int unsigned LINE_W    = 32'd2,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic          clk,
  input  logic          rst_n,
  bbox_overlay_if.slave vid,
  input  logic [9:0]    x_min,
  input  logic [9:0]    x_max,
  input  logic [9:0]    y_min,
  input  logic [9:0]    y_max,
  input  logic          box_en,
  output logic          box_drawn
);

  localparam logic [10:0] LW      = 11'(LINE_W);
  localparam logic [9:0]  CNT_MAX = 10'd1023;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  bx_min_q, bx_min_d, bx_max_q, bx_max_d;
  logic [9:0]  by_min_q, by_min_d, by_max_q, by_max_d;
  logic        box_vld_q, box_vld_d;
  logic        out_vsync_q, out_vsync_d;
  logic        out_href_q, out_href_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        box_drawn_q, box_drawn_d;

  logic        vs_rise_s, href_fall_s, box_ok_s;
  logic        inside_s, edge_s, border_s;
  logic [9:0]  cur_v_s;
  logic [10:0] dx_lo_s, dx_hi_s, dy_lo_s, dy_hi_s;

  // Next-state logic: counters, frame-start box latch, border decision.
  always_comb begin
    // out_vsync_q/out_href_q double as the previous-cycle copies for edge detection
    vs_rise_s   = vid.in_vsync & ~out_vsync_q;
    href_fall_s = out_href_q & ~vid.in_href;
    box_ok_s    = (x_min <= x_max) && (y_min <= y_max) &&
                  (x_max < IMG_HDISP) && (y_max < IMG_VDISP) && box_en;

    if (!vid.in_href) begin
      h_cnt_d = 10'd0;
    end else if (vid.in_valid && (h_cnt_q != CNT_MAX)) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q;
    end

    if (vs_rise_s) begin
      v_cnt_d = 10'd0;
    end else if (href_fall_s && (v_cnt_q != CNT_MAX)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end

    if (vs_rise_s) begin
      bx_min_d  = x_min;
      bx_max_d  = x_max;
      by_min_d  = y_min;
      by_max_d  = y_max;
      box_vld_d = box_ok_s;
      state_d   = ACTIVE;
    end else begin
      bx_min_d  = bx_min_q;
      bx_max_d  = bx_max_q;
      by_min_d  = by_min_q;
      by_max_d  = by_max_q;
      box_vld_d = box_vld_q;
      state_d   = state_q;
    end

    // A pixel coinciding with frame start sits on line 0 and sees the new box
    cur_v_s = vs_rise_s ? 10'd0 : v_cnt_q;

    dx_lo_s = {1'b0, h_cnt_q}  - {1'b0, bx_min_d};
    dx_hi_s = {1'b0, bx_max_d} - {1'b0, h_cnt_q};
    dy_lo_s = {1'b0, cur_v_s}  - {1'b0, by_min_d};
    dy_hi_s = {1'b0, by_max_d} - {1'b0, cur_v_s};

    inside_s = (h_cnt_q >= bx_min_d) && (h_cnt_q <= bx_max_d) &&
               (cur_v_s >= by_min_d) && (cur_v_s <= by_max_d) &&
               (h_cnt_q < IMG_HDISP) && (cur_v_s < IMG_VDISP);
    edge_s   = (dx_lo_s < LW) || (dx_hi_s < LW) || (dy_lo_s < LW) || (dy_hi_s < LW);
    border_s = (state_d == ACTIVE) && box_vld_d && inside_s && edge_s;

    if (vid.in_valid && border_s) begin
      out_data_d = BOX_COLOR;
    end else begin
      out_data_d = vid.in_data;
    end

    out_vsync_d = vid.in_vsync;
    out_href_d  = vid.in_href;
    out_valid_d = vid.in_valid;
    box_drawn_d = (state_d == ACTIVE) && box_vld_d;
  end

  // State, counters, shadow box and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_FRAME;
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 10'd0;
      bx_min_q    <= 10'd0;
      bx_max_q    <= 10'd0;
      by_min_q    <= 10'd0;
      by_max_q    <= 10'd0;
      box_vld_q   <= 1'b0;
      out_vsync_q <= 1'b0;
      out_href_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'd0;
      box_drawn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      bx_min_q    <= bx_min_d;
      bx_max_q    <= bx_max_d;
      by_min_q    <= by_min_d;
      by_max_q    <= by_max_d;
      box_vld_q   <= box_vld_d;
      out_vsync_q <= out_vsync_d;
      out_href_q  <= out_href_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      box_drawn_q <= box_drawn_d;
    end
  end

  assign vid.out_vsync = out_vsync_q;
  assign vid.out_href  = out_href_q;
  assign vid.out_valid = out_valid_q;
  assign vid.out_data  = out_data_q;
  assign box_drawn     = box_drawn_q;

endmodule

// File: doc/bbox_overlay.md
BBOX_OVERLAY -- requirements
Module: bbox_overlay

Interface
REQ-001 The block SHALL expose parameter IMG_HDISP, default 10'd640, active pixels per line.
REQ-002 The block SHALL expose parameter IMG_VDISP, default 10'd480, active lines per frame.
REQ-003 The block SHALL expose parameter LINE_W, default 2, border thickness in pixels (legal range 1..8).
REQ-004 The block SHALL expose parameter BOX_COLOR, default 16'hF800, RGB565 border colour.
REQ-005 Port: clk  input  1  pixel clock; the block uses one clock only; all state updates on its rising edge.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: in_vsync  input  1  frame sync, active-high; its rising edge marks frame start.
REQ-008 Port: in_href  input  1  line valid, active-high.
REQ-009 Port: in_valid  input  1  pixel strobe; in_data is valid when in_valid=1.
REQ-010 Port: in_data  input  16  RGB565 pixel.
REQ-011 Port: x_min, x_max, y_min, y_max  input  10 each  bounding box from the box-extraction stage.
REQ-012 Port: box_en  input  1  overlay enable; 0 forces pass-through.
REQ-013 Port: out_vsync, out_href, out_valid  output  1 each  in_vsync/in_href/in_valid delayed by 1 cycle.
REQ-014 Port: out_data  output  16  pixel, overlaid or passed through.
REQ-015 Port: box_drawn  output  1  1 while the currently latched box is valid and being drawn.

Function
REQ-016 All outputs SHALL be registered; latency from in_* to out_* SHALL be exactly 1 clk for every pixel.
REQ-017 A vsync rising edge SHALL be detected from in_vsync versus its 1-cycle registered copy.
REQ-018 h_cnt (10 b) SHALL give the coordinate of the current in_valid pixel; it SHALL increment after each in_valid=1 cycle and clear when in_href=0.
REQ-019 h_cnt SHALL saturate at 1023, never wrap.
REQ-020 v_cnt (10 b) SHALL increment on each in_href falling edge, saturate at 1023, and clear on a vsync rising edge.
REQ-021 Box inputs SHALL be sampled into shadow registers only on the vsync rising edge; changes mid-frame SHALL have no effect until the next frame.
REQ-022 The shadow box SHALL be valid only if x_min<=x_max, y_min<=y_max, x_max<IMG_HDISP, y_max<IMG_VDISP and box_en=1, all sampled on that same edge.
REQ-023 State machine: WAIT_FRAME (reset state, pure pass-through) -> ACTIVE on the first vsync rising edge; ACTIVE SHALL stay ACTIVE and re-latch on every later vsync rising edge.
REQ-024 In ACTIVE with a valid box, pixel (h,v) SHALL be a border pixel iff x_min<=h<=x_max, y_min<=v<=y_max, and any of the following holds: h-x_min<LINE_W, x_max-h<LINE_W, v-y_min<LINE_W, y_max-v<LINE_W.
REQ-025 Border arithmetic SHALL use 11-bit unsigned differences so no underflow aliasing occurs.
REQ-026 out_data SHALL be BOX_COLOR for a border pixel with in_valid=1, otherwise in_data delayed 1 clk.
REQ-027 Pixels with h>=IMG_HDISP or v>=IMG_VDISP SHALL pass through unchanged.
REQ-028 A degenerate box (x_min=x_max or y_min=y_max) SHALL draw as a single line or point.
REQ-029 A box thinner than 2*LINE_W SHALL be filled entirely with BOX_COLOR.
REQ-030 If a vsync rising edge and in_valid coincide, the pixel SHALL use the newly latched box and v=0.
REQ-031 box_drawn SHALL equal the shadow-valid flag while in ACTIVE and SHALL be 0 in WAIT_FRAME.

Reset
REQ-032 On rst_n=0 all outputs SHALL go to 0 immediately, without waiting for clk.
REQ-033 On rst_n=0 the counters, shadow registers and edge-detect registers SHALL clear, and the state SHALL return to WAIT_FRAME.
REQ-034 After deassertion mid-frame, the remainder of that frame SHALL pass through unchanged; overlay SHALL resume from the next vsync rising edge.

Verification
REQ-035 640x480 frame, box (100,200,50,150), LINE_W=2 -> pixel (100,50) and (199,149) = F800; (102,52) = input data; (99,50) = input data.
REQ-036 Box updated to (10,20,10,20) mid-frame -> current frame still draws (100,200,50,150); next frame draws the new box.
REQ-037 Box x_min=300 > x_max=200, or y_max=480 -> box_drawn=0, entire frame equals input delayed 1 clk.
REQ-038 Box (5,6,5,6), LINE_W=2 -> pixels (5..6, 5..6) all F800, neighbours unchanged.
REQ-039 rst_n pulsed low at line 240 -> outputs 0 during reset; rest of frame pass-through; next frame overlay restored; out_* always lag in_* by exactly 1 clk.
REQ-040 box_en=0 sampled at vsync rising edge -> full pass-through for that frame even if box_en rises mid-frame.
